handshake_monitor: RTL and testbench

Passive, bind-attached protocol checker for NUM_CH independent ready/valid channels. It generalises the single-property monitor to many channels and adds:
- sequential tracking of pending transfers
- data-stability and valid-drop checks
- stall timeouts
- per-channel transfer counters
- first-error capture

It drives nothing back into the design. It sits beside the monitored RTL via bind and exposes sticky status for assertions and debug.

---
 rtl/handshake_monitor_pkg.sv | 18 +
 rtl/handshake_monitor_ch.sv | 93 +++++++++
 rtl/handshake_monitor.sv | 107 ++++++++++
 tb/tb_handshake_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_monitor_pkg.sv
// Shared types and constants for the ready/valid handshake monitor.
package handshake_monitor_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ch_state_e;

    localparam int ERR_DROP    = 0;
    localparam int ERR_STABLE  = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int NUM_ERR     = 3;

    function automatic int fe_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/handshake_monitor_ch.sv
// One channel: IDLE/PENDING tracker, captured payload, stall counter,
// transfer counter and sticky drop/stable/timeout flags.
module handshake_monitor_ch
    import handshake_monitor_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               ASYNCRESETN,
    input  logic               valid_i,
    input  logic               ready_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic               clear_i,
    output logic [NUM_ERR-1:0] err_o,
    output logic [NUM_ERR-1:0] rise_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] TMO = SW'(TIMEOUT);

    ch_state_e          state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SW-1:0]      stall_q, stall_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_ERR-1:0] err_q, err_d;
    logic [NUM_ERR-1:0] set;
    logic               xfer;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        stall_d = stall_q;
        set     = '0;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (ready_i) begin
                        xfer = 1'b1;
                    end else begin
                        data_d  = data_i;
                        stall_d = SW'(1);
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                if (!valid_i) begin
                    set[ERR_DROP] = 1'b1;
                    state_d       = IDLE;
                end else begin
                    // stability is checked on the completing beat too
                    set[ERR_STABLE] = (data_i != data_q);
                    if (ready_i) begin
                        xfer    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        if (stall_q < TMO) stall_d = stall_q + SW'(1);
                        set[ERR_TIMEOUT] = (stall_d == TMO);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // clear wipes records only; tracking state keeps running
    assign err_d   = clear_i ? '0 : (err_q | set);
    assign cnt_d   = clear_i ? '0 : (cnt_q + CNT_W'(xfer));
    assign rise_o  = set & ~err_q & {NUM_ERR{~clear_i}};
    assign err_o   = err_q;
    assign count_o = cnt_q;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= IDLE;
            data_q  <= '0;
            stall_q <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/handshake_monitor.sv
// Passive multi-channel ready/valid protocol checker with sticky
// status, transfer counters and first-error capture.
module handshake_monitor
    import handshake_monitor_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int DATA_W    = 4,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 8,
    parameter bit ASSERT_EN = 1'b1
) (
    input  logic                           CLK,
    input  logic                           ASYNCRESETN,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH-1:0]              ch_ready,
    input  logic [NUM_CH*DATA_W-1:0]       ch_data,
    input  logic                           clear,
    output logic [NUM_CH-1:0]              err_drop,
    output logic [NUM_CH-1:0]              err_stable,
    output logic [NUM_CH-1:0]              err_timeout,
    output logic                           err_any,
    output logic [NUM_CH*CNT_W-1:0]        xfer_count,
    output logic                           first_err_valid,
    output logic [fe_width(NUM_CH)-1:0]    first_err_ch
);

    localparam int FE_W = fe_width(NUM_CH);

    logic [NUM_CH-1:0] rise_ch;
    logic [FE_W-1:0]   hit_idx;
    logic              fev_q, fev_d;
    logic [FE_W-1:0]   fch_q, fch_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [NUM_ERR-1:0] err_w;
        logic [NUM_ERR-1:0] rise_w;

        handshake_monitor_ch #(
            .DATA_W  (DATA_W),
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_ch (
            .CLK         (CLK),
            .ASYNCRESETN (ASYNCRESETN),
            .valid_i     (ch_valid[i]),
            .ready_i     (ch_ready[i]),
            .data_i      (ch_data[i*DATA_W +: DATA_W]),
            .clear_i     (clear),
            .err_o       (err_w),
            .rise_o      (rise_w),
            .count_o     (xfer_count[i*CNT_W +: CNT_W])
        );

        assign err_drop[i]    = err_w[ERR_DROP];
        assign err_stable[i]  = err_w[ERR_STABLE];
        assign err_timeout[i] = err_w[ERR_TIMEOUT];
        assign rise_ch[i]     = |rise_w;

        if (ASSERT_EN) begin : g_assert
            a_drop: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
                !$rose(err_drop[i]))
                else $error("handshake valid dropped on channel %0d", i);
            a_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
                !$rose(err_stable[i]))
                else $error("handshake data unstable on channel %0d", i);
            a_timeout: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
                !$rose(err_timeout[i]))
                else $error("handshake stall timeout on channel %0d", i);
        end
    end

    assign err_any = |{err_drop, err_stable, err_timeout};

    // lowest channel index wins on simultaneous first errors
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rise_ch[i]) hit_idx = FE_W'(i);
        end
    end

    always_comb begin
        fev_d = fev_q;
        fch_d = fch_q;
        if (clear) begin
            fev_d = 1'b0;
            fch_d = '0;
        end else if (!fev_q && |rise_ch) begin
            fev_d = 1'b1;
            fch_d = hit_idx;
        end
    end

    assign first_err_valid = fev_q;
    assign first_err_ch    = fch_q;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            fev_q <= 1'b0;
            fch_q <= '0;
        end else begin
            fev_q <= fev_d;
            fch_q <= fch_d;
        end
    end

endmodule

// File: tb/tb_handshake_monitor.sv
// Directed plus randomized bench for handshake_monitor against a
// transaction-level reference model.
module tb_handshake_monitor;

    localparam int NCH = 3;
    localparam int DW  = 4;
    localparam int TO  = 16;
    localparam int CW  = 8;

    logic              CLK = 1'b0;
    logic              ASYNCRESETN = 1'b0;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH-1:0]    ch_ready = '0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic              clear = 1'b0;
    logic [NCH-1:0]    err_drop, err_stable, err_timeout;
    logic              err_any;
    logic [NCH*CW-1:0] xfer_count;
    logic              first_err_valid;
    logic [1:0]        first_err_ch;

    handshake_monitor #(
        .NUM_CH    (NCH),
        .DATA_W    (DW),
        .TIMEOUT   (TO),
        .CNT_W     (CW),
        .ASSERT_EN (1'b0)
    ) dut (
        .CLK             (CLK),
        .ASYNCRESETN     (ASYNCRESETN),
        .ch_valid        (ch_valid),
        .ch_ready        (ch_ready),
        .ch_data         (ch_data),
        .clear           (clear),
        .err_drop        (err_drop),
        .err_stable      (err_stable),
        .err_timeout     (err_timeout),
        .err_any         (err_any),
        .xfer_count      (xfer_count),
        .first_err_valid (first_err_valid),
        .first_err_ch    (first_err_ch)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: a channel either holds an outstanding beat or not
    bit       busy[NCH];
    int       held[NCH];
    int       waited[NCH];
    int       done[NCH];
    bit [NCH-1:0] m_drop, m_stab, m_to;
    bit       m_fev;
    int       m_fch;

    function automatic void m_reset();
        for (int c = 0; c < NCH; c++) begin
            busy[c] = 0; held[c] = 0; waited[c] = 0; done[c] = 0;
        end
        m_drop = '0; m_stab = '0; m_to = '0;
        m_fev = 0; m_fch = 0;
    endfunction

    function automatic void m_edge();
        bit ev_d[NCH], ev_s[NCH], ev_t[NCH], got[NCH];
        int first;
        for (int c = 0; c < NCH; c++) begin
            bit v, r;
            int d;
            v = ch_valid[c]; r = ch_ready[c]; d = int'(ch_data[c*DW +: DW]);
            ev_d[c] = 0; ev_s[c] = 0; ev_t[c] = 0; got[c] = 0;
            if (!busy[c]) begin
                if (v && r) got[c] = 1;
                else if (v) begin busy[c] = 1; held[c] = d; waited[c] = 1; end
            end else if (!v) begin
                ev_d[c] = 1; busy[c] = 0;
            end else begin
                ev_s[c] = (d != held[c]);
                if (r) begin got[c] = 1; busy[c] = 0; end
                else begin
                    waited[c] = (waited[c] + 1 > TO) ? TO : waited[c] + 1;
                    ev_t[c] = (waited[c] == TO);
                end
            end
        end
        if (clear) begin
            for (int c = 0; c < NCH; c++) done[c] = 0;
            m_drop = '0; m_stab = '0; m_to = '0; m_fev = 0; m_fch = 0;
            return;
        end
        first = -1;
        for (int c = 0; c < NCH; c++) begin
            if (first < 0 && ((ev_d[c] && !m_drop[c]) || (ev_s[c] && !m_stab[c])
                              || (ev_t[c] && !m_to[c]))) first = c;
            if (ev_d[c]) m_drop[c] = 1;
            if (ev_s[c]) m_stab[c] = 1;
            if (ev_t[c]) m_to[c] = 1;
            if (got[c]) done[c] = (done[c] + 1) % (1 << CW);
        end
        if (!m_fev && first >= 0) begin m_fev = 1; m_fch = first; end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".drop"}, 32'(err_drop), 32'(m_drop));
        check({tag, ".stable"}, 32'(err_stable), 32'(m_stab));
        check({tag, ".timeout"}, 32'(err_timeout), 32'(m_to));
        check({tag, ".any"}, 32'(err_any), 32'(|{m_drop, m_stab, m_to}));
        for (int c = 0; c < NCH; c++)
            check({tag, ".cnt"}, 32'(xfer_count[c*CW +: CW]), 32'(done[c]));
        check({tag, ".fev"}, 32'(first_err_valid), 32'(m_fev));
        check({tag, ".fch"}, 32'(first_err_ch), 32'(m_fch));
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        m_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input int c, input bit v, input bit r, input int d);
        ch_valid[c] = v;
        ch_ready[c] = r;
        ch_data[c*DW +: DW] = DW'(d);
    endtask

    task automatic idle_all();
        ch_valid = '0; ch_ready = '0; clear = 1'b0;
    endtask

    task automatic do_clear();
        idle_all(); clear = 1'b1; tick("clr"); clear = 1'b0;
    endtask

    initial begin
        m_reset();
        #3;
        compare_all("reset");
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        tick("idle");

        // completed stall with stable data
        drive(1, 1, 0, 'hA);
        repeat (3) tick("t1stall");
        drive(1, 1, 1, 'hA); tick("t1done");
        idle_all(); tick("t1idle");
        check("t1.cnt1", 32'(xfer_count[CW +: CW]), 32'd1);
        check("t1.any", 32'(err_any), 32'd0);

        // valid drop
        drive(0, 1, 0, 'h2); tick("t2a");
        idle_all(); tick("t2b");
        check("t2.drop0", 32'(err_drop[0]), 32'd1);
        check("t2.fev", 32'(first_err_valid), 32'd1);
        check("t2.fch", 32'(first_err_ch), 32'd0);
        do_clear();

        // data change while pending
        drive(2, 1, 0, 'h3); tick("t3a");
        drive(2, 1, 0, 'h5); tick("t3b");
        check("t3.stable2", 32'(err_stable[2]), 32'd1);
        check("t3.any", 32'(err_any), 32'd1);
        drive(2, 1, 1, 'h5); tick("t3c");
        idle_all(); tick("t3d");
        do_clear();

        // timeout at exactly the TO-th sample
        drive(1, 1, 0, 'h7);
        repeat (TO - 1) tick("t4stall");
        check("t4.before", 32'(err_timeout[1]), 32'd0);
        tick("t4edge");
        check("t4.at", 32'(err_timeout[1]), 32'd1);
        repeat (3) tick("t4hold");
        drive(1, 1, 1, 'h7); tick("t4done");
        check("t4.cnt1", 32'(xfer_count[CW +: CW]), 32'd1);
        check("t4.sticky", 32'(err_timeout[1]), 32'd1);
        idle_all(); tick("t4idle");
        do_clear();

        // simultaneous errors: lowest index wins, record then holds
        drive(0, 1, 0, 'h1); drive(2, 1, 0, 'h1); tick("t5a");
        idle_all(); tick("t5b");
        check("t5.fch", 32'(first_err_ch), 32'd0);
        drive(1, 1, 0, 'h1); tick("t5c");
        idle_all(); tick("t5d");
        check("t5.hold", 32'(first_err_ch), 32'd0);
        check("t5.drop", 32'(err_drop), 32'd7);
        do_clear();

        // counter wrap, then clear coinciding with a transfer
        drive(0, 1, 1, 'h4);
        repeat (256) tick("t6wrap");
        check("t6.wrap", 32'(xfer_count[CW-1:0]), 32'd0);
        tick("t6one");
        clear = 1'b1; tick("t6clr"); clear = 1'b0;
        check("t6.clr", 32'(xfer_count[CW-1:0]), 32'd0);
        idle_all(); tick("t6idle");

        // reset mid-stall aborts tracking with no error
        drive(1, 1, 0, 'h9);
        repeat (10) tick("t7stall");
        #2 ASYNCRESETN = 1'b0;
        m_reset();
        #1 compare_all("t7rst");
        idle_all();
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        repeat (20) tick("t7after");
        check("t7.to", 32'(err_timeout), 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++)
                drive(c, $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
                      ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15))
                                                   : c);
            clear = ($urandom_range(0, 59) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
